// File: rtl/ifetch_sequencer_if.sv
// ifetch_sequencer_if: instruction ROM port, redirect request and decode-side handshake of the fetch sequencer
interface ifetch_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [31:0]       fetch_count;
    modport master (
        output imem_addr, out_valid, out_instr, out_pc, fetch_count,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, fetch_count,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch_sequencer.sv
// ifetch_sequencer: sequential fetch into a 2-entry output queue with redirect flush; IFETCH_PERF_COUNT_EN enables fetch_count
module ifetch_sequencer #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst,
    ifetch_sequencer_if.master io_bus
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tag;
    logic              r_infl;
    logic [1:0]        r_occ;
    logic [31:0]       r_qi [2];
    logic [ADDR_W-1:0] r_qp [2];
    logic              w_valid;
    logic              w_deq;
    logic              w_issue;
    logic              w_wi;
    always_comb begin
        w_valid = r_occ != 2'd0;
        w_deq   = w_valid && io_bus.out_ready;
        w_issue = !io_bus.redirect_valid && ({1'b0, r_occ} + {2'b0, r_infl} - {2'b0, w_deq} < 3'd2);
        w_wi    = r_occ[0] ^ w_deq;
    end
    assign io_bus.imem_addr = r_pc;
    assign io_bus.out_valid = w_valid;
    assign io_bus.out_instr = w_valid ? r_qi[0] : '0;
    assign io_bus.out_pc    = w_valid ? r_qp[0] : '0;
    // Entry 0 is the head; the returning word lands in the first free slot after any dequeue shift.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc   <= {RESET_PC[ADDR_W-1:2], 2'b00};
            r_infl <= 1'b0;
            r_occ  <= 2'd0;
        end else if (io_bus.redirect_valid) begin
            r_pc   <= {io_bus.redirect_pc[ADDR_W-1:2], 2'b00};
            r_infl <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            r_infl <= w_issue;
            r_tag  <= r_pc;
            if (w_issue) r_pc <= r_pc + ADDR_W'(4);
            if (w_deq) begin
                r_qi[0] <= r_qi[1];
                r_qp[0] <= r_qp[1];
            end
            if (r_infl) begin
                r_qi[w_wi] <= io_bus.imem_rdata;
                r_qp[w_wi] <= r_tag;
            end
            r_occ <= r_occ + {1'b0, r_infl} - {1'b0, w_deq};
        end
    end
`ifdef IFETCH_PERF_COUNT_EN
    logic [31:0] r_cnt;
    always_ff @(posedge clk) r_cnt <= !rst ? 32'd0 : r_cnt + {31'd0, w_deq};
    assign io_bus.fetch_count = r_cnt;
`else
    assign io_bus.fetch_count = 32'd0;
`endif
endmodule

// File: tb/tb_ifetch_sequencer.sv
// tb_ifetch_sequencer: randomized redirect/reset/backpressure stimulus scored against a sequential-PC fetch model
module tb_ifetch_sequencer;
    localparam int AW = 12;
    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    ifetch_sequencer_if #(.ADDR_W(AW)) bus ();
    ifetch_sequencer_if #(.ADDR_W(AW)) bus2 ();
    ifetch_sequencer #(.ADDR_W(AW), .RESET_PC(12'h000)) u_dut (.clk(clk), .rst(rst), .io_bus(bus));
    ifetch_sequencer #(.ADDR_W(AW), .RESET_PC(12'hFF8)) u_dut2 (.clk(clk), .rst(rst), .io_bus(bus2));
    assign bus2.out_ready      = 1'b1;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 12'h000;
    logic [31:0] rom [1024];
    initial for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + 32'(i);
    always @(posedge clk) begin
        bus.imem_rdata  <= rom[bus.imem_addr[AW-1:2]];
        bus2.imem_rdata <= rom[bus2.imem_addr[AW-1:2]];
    end
    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];
    logic pend = 1'b0;
    logic [AW-1:0] pend_pc = 12'h000;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Expected stream after a restart: consecutive words from the start address, wrapping the address space.
    task automatic restart(input logic [AW-1:0] start);
        logic [AW-1:0] p;
        p = start;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back('{p, rom[p[AW-1:2]]});
            p = p + 12'd4;
        end
    endtask
    task automatic step(input logic rv, input logic [AW-1:0] rpc, input logic rdy, input logic rstn);
        @(posedge clk);
        #1;
        if (pend) restart(pend_pc);
        rst = rstn;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.out_ready = rdy;
        pend = rv || !rstn;
        pend_pc = !rstn ? 12'h000 : {rpc[AW-1:2], 2'b00};
    endtask
    task automatic go(input logic rdy);
        step(1'b0, 12'h000, rdy, 1'b1);
    endtask
    logic          started = 1'b0;
    logic          pv = 1'b0;
    logic          px = 1'b0;
    logic          pf = 1'b0;
    logic [AW-1:0] ppc = 12'h000;
    logic [31:0]   pin = 32'd0;
    logic [31:0]   exp_cnt = 32'd0;
    int            since = 0;
    exp_t          e;
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                if (!bus.out_valid) chk("empty_zero", 32'(bus.out_pc) | bus.out_instr, 32'd0);
                if (since == 1 || since == 2) chk("flush_gap_valid", 32'(bus.out_valid), 32'd0);
                if (since == 3) chk("restart_latency_valid", 32'(bus.out_valid), 32'd1);
                if (pv && !px && !pf) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_pc", 32'(bus.out_pc), 32'(ppc));
                    chk("hold_instr", bus.out_instr, pin);
                end
                if (px && !pf) chk("throughput_valid", 32'(bus.out_valid), 32'd1);
                chk("imem_addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
                chk("fetch_count", bus.fetch_count, exp_cnt);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected: got pc %h with no expected entry", bus.out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", 32'(bus.out_pc), 32'(e.pc));
                        chk("sb_instr", bus.out_instr, e.instr);
                    end
                end
            end
            if (!rst) started = 1'b1;
            pf = !rst || bus.redirect_valid;
            px = bus.out_valid && bus.out_ready;
            pv = bus.out_valid;
            ppc = bus.out_pc;
            pin = bus.out_instr;
            since = pf ? 1 : (since < 100 ? since + 1 : since);
            if (!rst) exp_cnt = 32'd0;
`ifdef IFETCH_PERF_COUNT_EN
            else if (px) exp_cnt = exp_cnt + 32'd1;
`endif
        end
    end
    logic [AW-1:0] a_hold;
    logic [AW-1:0] p2;
    int r;
    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 12'h000;
        bus.out_ready = 1'b1;
        repeat (3) step(1'b0, 12'h000, 1'b1, 1'b0);
        go(1'b1);
        go(1'b1);
        chk("first_cycle_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            go(1'b1);
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk("stream_pc", 32'(bus.out_pc), 32'(4 * i));
            chk("stream_instr", bus.out_instr, 32'hA000_0000 + 32'(i));
            if (i < 4) begin
                p2 = 12'hFF8 + 12'(4 * i);
                chk("wrap_pc", 32'(bus2.out_pc), 32'(p2));
                chk("wrap_instr", bus2.out_instr, rom[p2[AW-1:2]]);
            end
        end
        a_hold = 12'h000;
        for (int i = 0; i < 6; i++) begin
            go(1'b0);
            if (i == 2) a_hold = bus.imem_addr;
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        chk("stall_pc_hold", 32'(bus.imem_addr), 32'(a_hold));
        step(1'b1, 12'h103, 1'b0, 1'b1);
        go(1'b1);
        chk("redirect_gap", 32'(bus.out_valid), 32'd0);
        go(1'b1);
        go(1'b1);
        chk("redirect_valid3", 32'(bus.out_valid), 32'd1);
        chk("redirect_pc3", 32'(bus.out_pc), 32'h100);
        chk("redirect_instr3", bus.out_instr, rom[64]);
        repeat (3) go(1'b1);
        step(1'b1, 12'h200, 1'b1, 1'b1);
        repeat (5) go(1'b1);
        step(1'b0, 12'h000, 1'b1, 1'b0);
        go(1'b1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_zero", 32'(bus.out_pc) | bus.out_instr, 32'd0);
        go(1'b1);
        go(1'b1);
        chk("reset_restart_pc", 32'(bus.out_pc), 32'h000);
        chk("reset_restart_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            step(r >= 1 && r < 6, 12'($urandom_range(0, 4095)), $urandom_range(0, 3) != 0, r != 0);
        end
        repeat (8) go(1'b1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
